seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter ON_CYCLES, default 8: cycles each digit enable stays asserted per slot, minimum 1.
REQ-003 SHALL have parameter DEAD_CYCLES, default 2: all-enables-off cycles before each digit slot, minimum 1.
REQ-004 SHALL have port CLK  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port i_Rst_L  in  1  asynchronous active-low reset.
REQ-006 SHALL have port i_Value  in  4*NUM_DIGITS  display value; nibble k drives digit k, digit 0 = bits [3:0].
REQ-007 SHALL have port i_Load  in  1  single-cycle strobe capturing i_Value.
REQ-008 SHALL have port o_Dec_Nibble  out  4  nibble to the shared registered binary-to-seven-segment decoder.
REQ-009 SHALL have port o_Digit_En  out  NUM_DIGITS  active-high, one-hot-or-zero digit enables.
REQ-010 SHALL have port o_Frame_Done  out  1  one-cycle pulse on the last cycle of each full scan.

Function
REQ-011 SHALL run FSM states DEAD -> SETUP -> ON -> DEAD continuously; no idle state.
REQ-012 DEAD SHALL last DEAD_CYCLES cycles with o_Digit_En all zero.
REQ-013 SETUP SHALL last exactly 1 cycle: o_Dec_Nibble shows the current digit's nibble, o_Digit_En zero, covering the decoder's 1-cycle register latency.
REQ-014 ON SHALL last ON_CYCLES cycles with the current digit's enable bit asserted and o_Dec_Nibble held stable.
REQ-015 Slot length SHALL be DEAD_CYCLES+1+ON_CYCLES; frame length SHALL be NUM_DIGITS slots.
REQ-016 Digit index SHALL advance 0,1,...,NUM_DIGITS-1 at each ON exit and wrap to 0.
REQ-017 o_Dec_Nibble SHALL hold its value through DEAD; it SHALL change only on entry to SETUP.
REQ-018 i_Load SHALL write i_Value into a pending register and set a pending flag; later loads within the same frame overwrite it (last wins).
REQ-019 The displayed (active) value SHALL change only at frame wrap: on the o_Frame_Done cycle, if i_Load is high, active <= i_Value; else if pending is set, active <= pending. The pending flag SHALL clear in both cases.
REQ-020 The active value SHALL never change mid-frame; no torn frames.
REQ-021 o_Frame_Done SHALL assert on the last ON cycle of digit NUM_DIGITS-1 only.
REQ-022 At most one o_Digit_En bit SHALL be high in any cycle.

Reset
REQ-023 While i_Rst_L is low, o_Digit_En=0, o_Dec_Nibble=0, o_Frame_Done=0, state=DEAD with the dead counter at 0, digit index=0, active=0, pending=0 and the pending flag cleared.
REQ-024 Reset assertion mid-slot SHALL drop o_Digit_En to 0 immediately (asynchronously).
REQ-025 After deassertion, the first enable (digit 0) SHALL assert DEAD_CYCLES+1 cycles later.

Configuration
REQ-026 Macro SEVEN_SEG_LZ_SUPPRESS_EN defined: digit k (k>0) SHALL be suppressed when its active nibble and all higher nibbles are zero. A suppressed digit runs its full slot timing but keeps its enable low in ON. Digit 0 SHALL never be suppressed.
REQ-027 Macro undefined: no suppression; every digit is enabled in its ON phase. Timing is identical in both builds.

Structure
REQ-028 Shared package seven_seg_pkg SHALL hold the FSM state enum (DEAD, SETUP, ON) and the nibble width constant 4.
REQ-029 Sub-module seven_seg_slot_timer SHALL own the slot-phase counter and emit phase-end strobes. The FSM, digit index and value registers SHALL stay in seven_seg_scan_ctrl.

Verification (NUM_DIGITS=4, ON_CYCLES=8, DEAD_CYCLES=2; slot=11, frame=44 cycles)
REQ-030 Release reset, no load -> o_Digit_En first 0001 at cycle 3, for 8 cycles; then 0010, 0100, 1000 at 11-cycle spacing; o_Frame_Done at cycle 43; o_Dec_Nibble=0 throughout.
REQ-031 Load 16'h1234 at cycle 5 -> the current frame still shows 0; from the next frame o_Dec_Nibble is 4,3,2,1 during digits 0..3.
REQ-032 Loads 16'hAAAA then 16'h5555 in the same frame, plus 16'hBEEF coincident with o_Frame_Done -> the next frame shows F,E,E,B (the coincident load wins).
REQ-033 Assert i_Rst_L low during digit 2 ON -> o_Digit_En=0 in the same cycle; after release, the scan restarts at digit 0 per REQ-025 with active=0.
REQ-034 SEVEN_SEG_LZ_SUPPRESS_EN, value 16'h0070 -> digits 0 and 1 enabled, digits 2 and 3 never enabled, slot timing unchanged. Value 16'h0000 -> only digit 0 enabled.
REQ-035 Every cycle of every test -> o_Digit_En has at most one bit set, and o_Dec_Nibble is stable while any enable is high.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seven_seg_pkg;

  // Width of one display digit's binary code.
  localparam int NIBBLE_W = 4;

  // Scan phases: blank gap, decoder setup, digit lit.
  typedef enum logic [1:0] {
    DEAD  = 2'd0,
    SETUP = 2'd1,
    ON    = 2'd2
  } scan_state_t;

  // Counter width able to hold 0..max(a,b)-1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_slot_timer.sv
// Phase counter for one digit slot; flags the last DEAD and ON cycles.
// Latency: strobes are combinational from the registered phase count.
// Backpressure: none; free-running, follows the state it is given.
module seven_seg_slot_timer
  import seven_seg_pkg::*;
#(
  parameter int ON_CYCLES   = 8,
  parameter int DEAD_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        i_Rst_L,
  input  scan_state_t i_State,
  output logic        o_Dead_End,
  output logic        o_On_End,
  output logic        o_On_End_Next
);

  localparam int CNT_W = cnt_width(ON_CYCLES, DEAD_CYCLES);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_PENULT = CNT_W'((ON_CYCLES > 1) ? ON_CYCLES - 2 : 0);

  logic [CNT_W-1:0] phase_cnt;

  assign o_Dead_End = (i_State == DEAD) && (phase_cnt == DEAD_LAST);
  assign o_On_End   = (i_State == ON)   && (phase_cnt == ON_LAST);
  // True when the following cycle will be the last ON cycle; lets the
  // controller register its frame pulse so it lands on that cycle.
  assign o_On_End_Next = (ON_CYCLES == 1) ? (i_State == SETUP)
                                          : ((i_State == ON) && (phase_cnt == ON_PENULT));

  // Count cycles within the current phase; restart at every phase change.
  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      phase_cnt <= '0;
    end else if (o_Dead_End || o_On_End || (i_State == SETUP)) begin
      phase_cnt <= '0;
    end else begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan: DEAD gap, 1-cycle decoder SETUP, ON per digit.
// Latency: new value shown from the frame after its load; first enable DEAD_CYCLES+1 after reset.
// Backpressure: none; loads are absorbed into a pending register (last wins).
// Build option: define SEVEN_SEG_LZ_SUPPRESS_EN to blank leading-zero digits.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int ON_CYCLES   = 8,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                           CLK,
  input  logic                           i_Rst_L,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] i_Value,
  input  logic                           i_Load,
  output logic [NIBBLE_W-1:0]            o_Dec_Nibble,
  output logic [NUM_DIGITS-1:0]          o_Digit_En,
  output logic                           o_Frame_Done
);

  localparam int VAL_W = NIBBLE_W * NUM_DIGITS;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_t            state;
  logic [IDX_W-1:0]       digit_idx;
  logic [VAL_W-1:0]       active_val;
  logic [VAL_W-1:0]       pend_val;
  logic                   pend_flag;
  logic                   dead_end;
  logic                   on_end;
  logic                   on_end_next;
  logic [NIBBLE_W-1:0]    cur_nibble;
  logic [NUM_DIGITS-1:0]  cur_onehot;
  logic                   suppress_cur;

  seven_seg_slot_timer #(
    .ON_CYCLES   (ON_CYCLES),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_slot_timer (
    .CLK           (CLK),
    .i_Rst_L       (i_Rst_L),
    .i_State       (state),
    .o_Dead_End    (dead_end),
    .o_On_End      (on_end),
    .o_On_End_Next (on_end_next)
  );

  assign cur_nibble = active_val[int'(digit_idx)*NIBBLE_W +: NIBBLE_W];
  assign cur_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx;

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] digit_blank;
  logic                  zeros_above;

  // A digit above 0 is blank when it and every higher nibble are zero.
  always_comb begin
    digit_blank = '0;
    zeros_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zeros_above    = zeros_above && (active_val[k*NIBBLE_W +: NIBBLE_W] == '0);
      digit_blank[k] = zeros_above;
    end
  end

  assign suppress_cur = digit_blank[digit_idx];
`else
  assign suppress_cur = 1'b0;
`endif

  // Scan FSM with registered nibble, enable and frame pulse outputs.
  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state        <= DEAD;
      digit_idx    <= '0;
      o_Dec_Nibble <= '0;
      o_Digit_En   <= '0;
      o_Frame_Done <= 1'b0;
    end else begin
      o_Frame_Done <= on_end_next && (digit_idx == LAST_IDX);
      case (state)
        DEAD: begin
          if (dead_end) begin
            state        <= SETUP;
            o_Dec_Nibble <= cur_nibble;
          end
        end
        SETUP: begin
          state      <= ON;
          o_Digit_En <= suppress_cur ? '0 : cur_onehot;
        end
        ON: begin
          if (on_end) begin
            state      <= DEAD;
            o_Digit_En <= '0;
            digit_idx  <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
          end
        end
        default: begin
          state      <= DEAD;
          o_Digit_En <= '0;
        end
      endcase
    end
  end

  // Double-buffered display value: swap only on the frame pulse so no frame tears.
  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      active_val <= '0;
      pend_val   <= '0;
      pend_flag  <= 1'b0;
    end else if (o_Frame_Done) begin
      if (i_Load) begin
        active_val <= i_Value;
      end else if (pend_flag) begin
        active_val <= pend_val;
      end
      pend_flag <= 1'b0;
    end else if (i_Load) begin
      pend_val  <= i_Value;
      pend_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with default geometry (4 digits, 8 on, 2 dead).
// Latency: n/a.
// Backpressure: n/a.
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int ONC   = 8;
  localparam int DC    = 2;
  localparam int SLOT  = DC + 1 + ONC;
  localparam int FRAME = ND * SLOT;

  logic        CLK = 1'b0;
  logic        i_Rst_L;
  logic [15:0] i_Value;
  logic        i_Load;
  logic [3:0]  o_Dec_Nibble;
  logic [3:0]  o_Digit_En;
  logic        o_Frame_Done;

  always #5 CLK = ~CLK;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .ON_CYCLES   (ONC),
    .DEAD_CYCLES (DC)
  ) dut (
    .CLK          (CLK),
    .i_Rst_L      (i_Rst_L),
    .i_Value      (i_Value),
    .i_Load       (i_Load),
    .o_Dec_Nibble (o_Dec_Nibble),
    .o_Digit_En   (o_Digit_En),
    .o_Frame_Done (o_Frame_Done)
  );

  int          n_total;
  int          n_bad;
  int          t;
  logic [15:0] m_active;
  logic [15:0] m_pend;
  logic        m_pflag;
  logic [3:0]  m_shown;
  logic [3:0]  prev_en;
  logic [3:0]  prev_nib;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", tag, t, obs, exp);
    end
  endtask

  function automatic logic [3:0] nib_of(input logic [15:0] v, input int k);
    return 4'((v >> (4 * k)) & 16'h000F);
  endfunction

  // Expected enables from the position inside the frame.
  function automatic logic [3:0] model_en(input int tt);
    int         ph;
    int         d;
    logic [3:0] e;
    ph = tt % SLOT;
    d  = (tt / SLOT) % ND;
    e  = '0;
    if (ph >= DC + 1) begin
      e = 4'(1 << d);
`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
      if (d > 0 && (m_active >> (4 * d)) == 16'h0) e = '0;
`endif
    end
    return e;
  endfunction

  task automatic model_reset();
    m_active = '0;
    m_pend   = '0;
    m_pflag  = 1'b0;
    m_shown  = '0;
    prev_en  = '0;
    prev_nib = '0;
  endtask

  // One clock cycle: called at the falling edge inside cycle t.
  task automatic do_cycle(input logic ld, input logic [15:0] val);
    int ph;
    int d;
    ph = t % SLOT;
    d  = (t / SLOT) % ND;
    if (ph == DC) m_shown = nib_of(m_active, d);
    chk_eq("digit_en", o_Digit_En, model_en(t));
    chk_eq("dec_nibble", o_Dec_Nibble, m_shown);
    chk_eq("frame_done", o_Frame_Done, (t % FRAME) == FRAME - 1);
    chk_eq("onehot", $countones(o_Digit_En) <= 1, 1);
    if (o_Digit_En != 0 && prev_en != 0) chk_eq("nib_stable", o_Dec_Nibble, prev_nib);
    prev_en  = o_Digit_En;
    prev_nib = o_Dec_Nibble;
    i_Load   = ld;
    i_Value  = ld ? val : 16'($urandom);
    if ((t % FRAME) == FRAME - 1) begin
      if (ld) m_active = val;
      else if (m_pflag) m_active = m_pend;
      m_pflag = 1'b0;
    end else if (ld) begin
      m_pend  = val;
      m_pflag = 1'b1;
    end
    @(negedge CLK);
    t++;
  endtask

  task automatic rand_cycle();
    logic        ld;
    logic [15:0] v;
    ld = ($urandom_range(0, 11) == 0);
    v  = 16'($urandom) >> (4 * $urandom_range(0, 3));
    do_cycle(ld, v);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    t       = 0;
    i_Rst_L = 1'b0;
    i_Load  = 1'b0;
    i_Value = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk_eq("rst_en", o_Digit_En, 0);
    chk_eq("rst_nib", o_Dec_Nibble, 0);
    chk_eq("rst_fd", o_Frame_Done, 0);

    // Directed: idle frame, then 1234, then AAAA/5555/coincident BEEF.
    i_Rst_L = 1'b1;
    t = 0;
    while (t < 3 * FRAME) begin
      logic        ld;
      logic [15:0] v;
      ld = 1'b0;
      v  = '0;
      case (t)
        5:  begin ld = 1'b1; v = 16'h1234; end
        54: begin ld = 1'b1; v = 16'hAAAA; end
        64: begin ld = 1'b1; v = 16'h5555; end
        87: begin ld = 1'b1; v = 16'hBEEF; end
        default: ;
      endcase
      case (t)
        2:   chk_eq("setup_no_en", o_Digit_En, 4'b0000);
        3:   chk_eq("first_en", o_Digit_En, 4'b0001);
        25:  chk_eq("d2_en", o_Digit_En, 4'b0100);
        43:  chk_eq("first_fd", o_Frame_Done, 1);
        49:  chk_eq("f1_d0", o_Dec_Nibble, 4'h4);
        60:  chk_eq("f1_d1", o_Dec_Nibble, 4'h3);
        71:  chk_eq("f1_d2", o_Dec_Nibble, 4'h2);
        82:  chk_eq("f1_d3", o_Dec_Nibble, 4'h1);
        93:  chk_eq("f2_d0", o_Dec_Nibble, 4'hF);
        104: chk_eq("f2_d1", o_Dec_Nibble, 4'hE);
        115: chk_eq("f2_d2", o_Dec_Nibble, 4'hE);
        126: chk_eq("f2_d3", o_Dec_Nibble, 4'hB);
        default: ;
      endcase
      do_cycle(ld, v);
    end

    // Leading-zero patterns, each held for two frames.
    do_cycle(1'b1, 16'h0070);
    repeat (2 * FRAME) do_cycle(1'b0, 16'h0);
    do_cycle(1'b1, 16'h0000);
    repeat (2 * FRAME) do_cycle(1'b0, 16'h0);

    // Randomized loads.
    repeat (20 * FRAME) rand_cycle();

    // Reset in the middle of digit 2 ON.
    for (int i = 0; i < FRAME && (t % FRAME) != 2 * SLOT + 5; i++) rand_cycle();
    chk_eq("pre_rst_en", o_Digit_En, model_en(t));
    i_Rst_L = 1'b0;
    #1;
    chk_eq("async_rst_en", o_Digit_En, 0);
    chk_eq("async_rst_nib", o_Dec_Nibble, 0);
    chk_eq("async_rst_fd", o_Frame_Done, 0);
    model_reset();
    i_Load = 1'b0;
    repeat (2) @(negedge CLK);
    chk_eq("hold_rst_en", o_Digit_En, 0);
    i_Rst_L = 1'b1;
    t = 0;
    while (t < 3 * FRAME) begin
      if (t == 3) chk_eq("restart_en", o_Digit_En, 4'b0001);
      if (t == 5) chk_eq("restart_nib", o_Dec_Nibble, 4'h0);
      rand_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
